// File: rtl/pipe_issue_unit_if.sv
// Issue bus from the issue front end to the 4-stage ALU pipeline.
// master: drives issue_valid and the registered instruction fields.
// slave : the pipeline side that consumes them.
interface pipe_issue_unit_if;
   logic       issue_valid;
   logic [3:0] rs1;
   logic [3:0] rs2;
   logic [3:0] rd;
   logic [3:0] func;
   logic [7:0] addr;

   modport master (
      output issue_valid,
      output rs1,
      output rs2,
      output rd,
      output func,
      output addr
   );

   modport slave (
      input issue_valid,
      input rs1,
      input rs2,
      input rd,
      input func,
      input addr
   );
endinterface

// File: rtl/pipe_issue_unit.sv
// Issue front end: holds a small program, steps through it and issues
// instructions to a no-forwarding pipeline, stalling on in-flight rd.
// Ports: clk, rst_n (async low); prog_we/prog_addr/prog_data load the
// program in IDLE; start runs from entry 0; busy/done report the run;
// issue_count/stall_count are saturating per-run counters; bus is the
// registered issue interface (master side).
module pipe_issue_unit #(
   parameter int PROG_DEPTH = 16,
   parameter int HAZ_WIN    = 3
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          prog_we,
   input  logic [$clog2(PROG_DEPTH)-1:0] prog_addr,
   input  logic [23:0]                   prog_data,
   input  logic                          start,
   output logic                          busy,
   output logic                          done,
   output logic [7:0]                    issue_count,
   output logic [7:0]                    stall_count,
   pipe_issue_unit_if.master             bus
);

   localparam int AW = $clog2(PROG_DEPTH);
   localparam logic [AW-1:0] PC_LAST = AW'(PROG_DEPTH - 1);

   typedef struct packed {
      logic [3:0] func;
      logic [3:0] rs1;
      logic [3:0] rs2;
      logic [3:0] rd;
      logic [7:0] addr;
   } instr_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN
   } state_t;

   state_t state, state_d;

   logic [23:0]   prog [PROG_DEPTH];
   logic [AW-1:0] pc;
   instr_t        cand;

   logic [HAZ_WIN-1:0]      sb_v;
   logic [HAZ_WIN-1:0][3:0] sb_rd;

   logic rd1, rd2;
   logic hazard;
   logic is_halt;
   logic pc_last;
   logic do_issue;
   logic do_stall;
   logic fin;

   // Program store: no reset, so contents survive rst_n.
   always_ff @(posedge clk) begin
      if (prog_we && state == S_IDLE)
         prog[prog_addr] <= prog_data;
   end

   assign cand    = instr_t'(prog[pc]);
   assign is_halt = (cand.func == 4'hF);
   assign pc_last = (pc == PC_LAST);
   assign busy    = (state != S_IDLE);

   // Which source fields the candidate actually reads.
   always_comb begin
      rd1 = 1'b0;
      rd2 = 1'b0;
      case (cand.func)
         4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd7: begin
            rd1 = 1'b1;
            rd2 = 1'b1;
         end
         4'd3, 4'd8, 4'd10, 4'd11: rd1 = 1'b1;
         4'd4, 4'd9:               rd2 = 1'b1;
         default: ;
      endcase
   end

   // Only sources that are really read can collide with a pending rd.
   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < HAZ_WIN; i++) begin
         if (sb_v[i] &&
             ((rd1 && sb_rd[i] == cand.rs1) ||
              (rd2 && sb_rd[i] == cand.rs2)))
            hazard = 1'b1;
      end
   end

   always_comb begin
      state_d  = state;
      do_issue = 1'b0;
      do_stall = 1'b0;
      fin      = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (start)
               state_d = S_RUN;
         end
         S_RUN: begin
            if (is_halt) begin
               state_d = S_DRAIN;
            end else if (hazard) begin
               do_stall = 1'b1;
            end else begin
               do_issue = 1'b1;
               if (pc_last)
                  state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (sb_v == '0) begin
               state_d = S_IDLE;
               fin     = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Scoreboard: a slot enters on issue and ages out after HAZ_WIN
   // cycles, which is when the pipeline has written rd back.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sb_v  <= '0;
         sb_rd <= '0;
      end else begin
         sb_v[0]  <= do_issue;
         sb_rd[0] <= cand.rd;
         for (int i = 1; i < HAZ_WIN; i++) begin
            sb_v[i]  <= sb_v[i-1];
            sb_rd[i] <= sb_rd[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         pc          <= '0;
         done        <= 1'b0;
         issue_count <= '0;
         stall_count <= '0;
      end else begin
         state <= state_d;
         done  <= fin;
         if (state == S_IDLE && start) begin
            pc          <= '0;
            issue_count <= '0;
            stall_count <= '0;
         end
         if (do_issue) begin
            // The last entry drains instead of wrapping pc.
            if (!pc_last)
               pc <= pc + 1'b1;
            if (issue_count != 8'hFF)
               issue_count <= issue_count + 8'd1;
         end
         if (do_stall && stall_count != 8'hFF)
            stall_count <= stall_count + 8'd1;
      end
   end

   // Fields hold their last value on non-issue cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.issue_valid <= 1'b0;
         bus.func        <= '0;
         bus.rs1         <= '0;
         bus.rs2         <= '0;
         bus.rd          <= '0;
         bus.addr        <= '0;
      end else begin
         bus.issue_valid <= do_issue;
         if (do_issue) begin
            bus.func <= cand.func;
            bus.rs1  <= cand.rs1;
            bus.rs2  <= cand.rs2;
            bus.rd   <= cand.rd;
            bus.addr <= cand.addr;
         end
      end
   end

endmodule
